// File: rtl/divider_ctrl_pkg.sv
// Shared types and helpers for the SAR divider controller and its divider model.
package divider_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} sar_state_t;

  // Divider ratio for a tap code: code / 2**code_w.
  function automatic real code_to_ratio(input int unsigned code, input int unsigned code_w);
    return real'(code) / (2.0 ** code_w);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times the settle wait after each code change.
module settle_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  output logic             o_zero
);

  logic [Width-1:0] r_cnt;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - Width'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/divider_sar_ctrl.sv
// Successive-approximation controller that searches for the largest divider tap code
// whose fed-back output voltage does not exceed the requested target.
module divider_sar_ctrl
  import divider_ctrl_pkg::*;
#(
  parameter int unsigned CODE_W        = 8,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  real               i_target,
  input  real               i_vout_fb,
  output logic [CODE_W-1:0] o_code_out,
  output logic              o_busy,
  output logic              o_done,
  output logic [CODE_W-1:0] o_result_code
);

  localparam int unsigned CntW = (SETTLE_CYCLES == 0) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned IdxW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [CntW-1:0]   CntLoad = CntW'(SETTLE_CYCLES);
  localparam logic [IdxW-1:0]   IdxMsb  = IdxW'(CODE_W - 1);
  localparam logic [CODE_W-1:0] CodeMsb = CODE_W'(1) << (CODE_W - 1);

  sar_state_t        r_state;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] r_result;
  logic [IdxW-1:0]   r_bit_idx;
  logic              r_done;
  logic              r_busy;
  logic              r_ready;
  real               r_target;

  logic              w_accept;
  logic              w_load;
  logic              w_zero;
  logic              w_last_bit;
  logic              w_keep;
  logic [CODE_W-1:0] w_bit_mask;
  logic [CODE_W-1:0] w_kept_code;
  logic [CODE_W-1:0] w_next_code;

  // Trial decision for the current bit and the code for the following trial.
  always_comb begin
    w_accept    = r_ready && i_req_valid;
    w_last_bit  = (r_bit_idx == '0);
    // Inclusive compare: equality keeps the bit.
    w_keep      = !(i_vout_fb > r_target);
    w_bit_mask  = CODE_W'(1) << r_bit_idx;
    w_kept_code = w_keep ? r_code : (r_code & ~w_bit_mask);
    w_next_code = w_kept_code | (w_bit_mask >> 1);
    // Counter reloads exactly when a new code is driven to the divider.
    w_load      = w_accept || ((r_state == SETTLE) && w_zero && !w_last_bit);
  end

  settle_timer #(
    .Width (CntW)
  ) u_settle_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (CntLoad),
    .o_zero     (w_zero)
  );

  // Search FSM with registered handshake, status and code outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_code    <= '0;
      r_result  <= '0;
      r_bit_idx <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b1;
      r_target  <= 0.0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_target  <= i_target;
            r_code    <= CodeMsb;
            r_bit_idx <= IdxMsb;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
            r_state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (w_zero) begin
            if (w_last_bit) begin
              r_code   <= w_kept_code;
              r_result <= w_kept_code;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= DONE;
            end else begin
              r_code    <= w_next_code;
              r_bit_idx <= r_bit_idx - IdxW'(1);
            end
          end
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_req_ready   = r_ready;
  assign o_code_out    = r_code;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_result_code = r_result;

endmodule

// File: tb/tb_divider_sar_ctrl.sv
// Closed-loop bench: SAR controller driving a real-valued divider model with vin = 5 V.
module tb_divider_sar_ctrl;
  import divider_ctrl_pkg::*;

  localparam real VIN = 5.0;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  real        target;
  real        vout;
  logic [7:0] code;
  logic       busy;
  logic       done;
  logic [7:0] result;

  // Zero-settle instance.
  logic       rst0;
  logic       req_valid0;
  logic       req_ready0;
  real        target0;
  real        vout0;
  logic [7:0] code0;
  logic       busy0;
  logic       done0;
  logic [7:0] result0;

  // Divider models.
  assign vout  = VIN * code_to_ratio(int'(code), 8);
  assign vout0 = VIN * code_to_ratio(int'(code0), 8);

  divider_sar_ctrl #(
    .CODE_W        (8),
    .SETTLE_CYCLES (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_target      (target),
    .i_vout_fb     (vout),
    .o_code_out    (code),
    .o_busy        (busy),
    .o_done        (done),
    .o_result_code (result)
  );

  divider_sar_ctrl #(
    .CODE_W        (8),
    .SETTLE_CYCLES (0)
  ) dut0 (
    .i_clk         (clk),
    .i_rst         (rst0),
    .i_req_valid   (req_valid0),
    .o_req_ready   (req_ready0),
    .i_target      (target0),
    .i_vout_fb     (vout0),
    .o_code_out    (code0),
    .o_busy        (busy0),
    .o_done        (done0),
    .o_result_code (result0)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference SAR over the ideal divider transfer function.
  function automatic int ref_sar(input real t);
    int c = 0;
    for (int b = 7; b >= 0; b--) begin
      int tr = c | (1 << b);
      if (VIN * real'(tr) / 256.0 <= t) c = tr;
    end
    return c;
  endfunction

  task automatic pop_check(input string tag);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, sb.size(), 1);
    end else begin
      int exp = sb.pop_front();
      chk({tag, "_result"}, result, exp);
    end
  endtask

  // Accept one request, wait for done, check result against the scoreboard.
  task automatic do_search(input real tgt, input int exp, input string tag, input bit chk_lat);
    int n = 0;
    target    = tgt;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    sb.push_back(exp);
    chk({tag, "_busy"}, busy, 1);
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done, 1);
    if (chk_lat) begin
      chk({tag, "_latency"}, n, 40);
      chk({tag, "_busy_in_done"}, busy, 0);
    end
    pop_check(tag);
    tick();
    chk({tag, "_ready_after"}, req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int accepts;
    int done_seen;
    logic prev_busy;
    real tgt;

    rst        = 1'b1;
    req_valid  = 1'b0;
    target     = 0.0;
    rst0       = 1'b1;
    req_valid0 = 1'b0;
    target0    = 0.0;
    tick();
    tick();

    // Reset values.
    chk("rst_code", code, 0);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    rst  = 1'b0;
    rst0 = 1'b0;
    tick();

    // Mid-scale and ordinary targets, plus both range boundaries.
    do_search(2.5, 128, "t1_2v5", 1'b1);
    do_search(1.0, 51, "t2_1v0", 1'b1);
    do_search(6.0, 255, "t2_6v0", 1'b0);
    do_search(-0.1, 0, "t2_neg", 1'b0);

    // Held valid with a mid-search target change: one accept, original target wins.
    target    = 2.5;
    req_valid = 1'b1;
    tick();
    sb.push_back(128);
    chk("t3_busy", busy, 1);
    accepts   = 1;
    prev_busy = busy;
    n         = 0;
    while (!done && n < 200) begin
      tick();
      n++;
      if (n == 10) target = 0.5;
      if (busy && !prev_busy) accepts++;
      prev_busy = busy;
    end
    chk("t3_done", done, 1);
    chk("t3_latency", n, 40);
    chk("t3_accepts", accepts, 1);
    pop_check("t3");
    tick();
    chk("t3_idle_ready", req_ready, 1);
    chk("t3_idle_busy", busy, 0);
    tick();
    chk("t3_reaccept", busy, 1);
    sb.push_back(25);
    req_valid = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("t3b_done", done, 1);
    pop_check("t3b");
    tick();

    // Reset 20 edges into a search abandons it silently.
    target    = 2.5;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_seen++;
    end
    rst = 1'b1;
    #1;
    chk("t4_code", code, 0);
    chk("t4_busy", busy, 0);
    chk("t4_result", result, 0);
    chk("t4_ready", req_ready, 1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done) done_seen++;
    end
    chk("t4_no_done", done_seen, 0);
    do_search(2.5, 128, "t4_after", 1'b1);

    // Zero settle cycles.
    target0    = 2.5;
    req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
    chk("t5_busy", busy0, 1);
    n = 0;
    while (!done0 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_done", done0, 1);
    chk("t5_latency", n, 8);
    chk("t5_result", result0, 128);
    tick();

    // Random targets against the reference SAR.
    for (int i = 0; i < 100; i++) begin
      tgt = real'($urandom_range(0, 500000)) / 100000.0;
      do_search(tgt, ref_sar(tgt), $sformatf("t6_%0d", i), 1'b0);
    end

    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
